// File: rtl/seq_alu_if.sv
// +----------------------------------------------------------------------------+
// | seq_alu_if : start/busy/done request bus between control unit and seq_alu  |
// | Rev 1.0    : initial release; flags member present with SEQ_ALU_FLAGS_EN   |
// +----------------------------------------------------------------------------+
`default_nettype none

interface seq_alu_if #(
  parameter int WIDTH = 32
);
  logic                 start;
  logic [4:0]           operation;
  logic [WIDTH-1:0]     Y;
  logic [WIDTH-1:0]     B;
  logic [2*WIDTH-1:0]   C;
  logic                 busy;
  logic                 done;
  logic                 div_zero;
`ifdef SEQ_ALU_FLAGS_EN
  logic [2:0]           flags;
`endif

  modport master (
    output start, operation, Y, B,
    input  C, busy, done, div_zero
`ifdef SEQ_ALU_FLAGS_EN
    , input flags
`endif
  );

  modport slave (
    input  start, operation, Y, B,
    output C, busy, done, div_zero
`ifdef SEQ_ALU_FLAGS_EN
    , output flags
`endif
  );
endinterface

`default_nettype wire

// File: rtl/seq_alu.sv
// +----------------------------------------------------------------------------+
// | seq_alu : multi-cycle ALU, 1-clock simple ops, iterative signed mul/div    |
// | Rev 1.0 : initial release; optional {N,Z,V} flags via SEQ_ALU_FLAGS_EN     |
// +----------------------------------------------------------------------------+
`default_nettype none

module seq_alu #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = $clog2(WIDTH)
) (
  input  wire logic clock,
  input  wire logic clear,
  seq_alu_if.slave  bus
);
  localparam int W2    = 2 * WIDTH;
  localparam int CNT_W = $clog2(WIDTH) + 1;

  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_AND  = 5'b00101;
  localparam logic [4:0] OP_OR   = 5'b00110;
  localparam logic [4:0] OP_SHR  = 5'b00111;
  localparam logic [4:0] OP_SHRA = 5'b01000;
  localparam logic [4:0] OP_SHL  = 5'b01001;
  localparam logic [4:0] OP_ROR  = 5'b01010;
  localparam logic [4:0] OP_ROL  = 5'b01011;
  localparam logic [4:0] OP_MUL  = 5'b01111;
  localparam logic [4:0] OP_DIV  = 5'b10000;
  localparam logic [4:0] OP_NEG  = 5'b10001;
  localparam logic [4:0] OP_NOT  = 5'b10010;

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_ITER = 2'd1, S_FIX = 2'd2} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [W2-1:0]      p_q, p_d;
  logic               div_q, div_d, sgn_q, sgn_d, ysgn_q, ysgn_d, dz_q, dz_d;
  logic [W2-1:0]      c_q, c_d;
  logic               done_q, done_d, busy_q, busy_d, dzf_q, dzf_d;
  logic [2:0]         flags_q, flags_d;

  logic [WIDTH-1:0]   w_sres, w_yabs, w_babs, w_quo, w_rem;
  logic               w_v;
  logic [W2-1:0]      w_rot, w_rot2, w_mul_nxt, w_div_nxt, w_fix;
  logic [WIDTH:0]     w_madd, w_dtry;
  logic [W2:0]        w_dsh;

  // Single-cycle result; also evaluated for mul/div but only captured on simple ops
  always_comb begin
    w_sres = '0;
    w_v    = 1'b0;
    w_rot  = {bus.Y, bus.Y};
    w_rot2 = '0;
    case (bus.operation)
      OP_ADD: begin
        w_sres = bus.Y + bus.B;
        w_v    = (bus.Y[WIDTH-1] == bus.B[WIDTH-1]) && (w_sres[WIDTH-1] != bus.Y[WIDTH-1]);
      end
      OP_SUB: begin
        w_sres = bus.Y - bus.B;
        w_v    = (bus.Y[WIDTH-1] != bus.B[WIDTH-1]) && (w_sres[WIDTH-1] != bus.Y[WIDTH-1]);
      end
      OP_AND:  w_sres = bus.Y & bus.B;
      OP_OR:   w_sres = bus.Y | bus.B;
      OP_SHR:  w_sres = bus.Y >> bus.B[SHAMT_W-1:0];
      OP_SHRA: w_sres = $signed(bus.Y) >>> bus.B[SHAMT_W-1:0];
      OP_SHL:  w_sres = bus.Y << bus.B[SHAMT_W-1:0];
      OP_ROR: begin
        w_rot2 = w_rot >> bus.B[SHAMT_W-1:0];
        w_sres = w_rot2[WIDTH-1:0];
      end
      OP_ROL: begin
        w_rot2 = w_rot << bus.B[SHAMT_W-1:0];
        w_sres = w_rot2[W2-1:WIDTH];
      end
      OP_NEG: begin
        w_sres = -bus.B;
        w_v    = (bus.B == {1'b1, {(WIDTH-1){1'b0}}});
      end
      OP_NOT:  w_sres = ~bus.B;
      default: w_sres = '0;
    endcase
  end

  // p_q holds {HI, LO}: product accumulator / multiplier, or remainder / quotient
  always_comb begin
    w_yabs    = bus.Y[WIDTH-1] ? -bus.Y : bus.Y;
    w_babs    = bus.B[WIDTH-1] ? -bus.B : bus.B;
    w_madd    = {1'b0, p_q[W2-1:WIDTH]} + (p_q[0] ? {1'b0, b_q} : {(WIDTH+1){1'b0}});
    w_mul_nxt = {w_madd, p_q[WIDTH-1:1]};
    w_dsh     = {p_q, 1'b0};
    w_dtry    = w_dsh[W2:WIDTH] - {1'b0, b_q};
    w_div_nxt = w_dtry[WIDTH] ? w_dsh[W2-1:0] : {w_dtry[WIDTH-1:0], w_dsh[WIDTH-1:1], 1'b1};
    w_quo     = p_q[WIDTH-1:0];
    w_rem     = p_q[W2-1:WIDTH];
    if (div_q) begin
      // With B=0 the remainder magnitude is |Y|, so the sign fix restores Y in HI
      w_fix = {(ysgn_q ? -w_rem : w_rem), (dz_q ? {WIDTH{1'b1}} : (sgn_q ? -w_quo : w_quo))};
    end else begin
      w_fix = sgn_q ? -p_q : p_q;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    b_d     = b_q;
    p_d     = p_q;
    div_d   = div_q;
    sgn_d   = sgn_q;
    ysgn_d  = ysgn_q;
    dz_d    = dz_q;
    c_d     = c_q;
    done_d  = 1'b0;
    busy_d  = busy_q;
    dzf_d   = dzf_q;
    flags_d = flags_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          dzf_d = 1'b0;
          if ((bus.operation == OP_MUL) || (bus.operation == OP_DIV)) begin
            b_d     = w_babs;
            p_d     = {{WIDTH{1'b0}}, w_yabs};
            div_d   = (bus.operation == OP_DIV);
            sgn_d   = bus.Y[WIDTH-1] ^ bus.B[WIDTH-1];
            ysgn_d  = bus.Y[WIDTH-1];
            dz_d    = (bus.B == '0);
            cnt_d   = CNT_W'(WIDTH);
            busy_d  = 1'b1;
            state_d = S_ITER;
          end else begin
            c_d     = {{WIDTH{1'b0}}, w_sres};
            done_d  = 1'b1;
            flags_d = {w_sres[WIDTH-1], (w_sres == '0), w_v};
          end
        end
      end
      S_ITER: begin
        p_d   = div_q ? w_div_nxt : w_mul_nxt;
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CNT_W'(1)) begin
          state_d = S_FIX;
        end
      end
      S_FIX: begin
        c_d     = w_fix;
        done_d  = 1'b1;
        busy_d  = 1'b0;
        dzf_d   = div_q & dz_q;
        flags_d = {w_fix[W2-1], (w_fix == '0), 1'b0};
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      b_q     <= '0;
      p_q     <= '0;
      div_q   <= 1'b0;
      sgn_q   <= 1'b0;
      ysgn_q  <= 1'b0;
      dz_q    <= 1'b0;
      c_q     <= '0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
      dzf_q   <= 1'b0;
      flags_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      b_q     <= b_d;
      p_q     <= p_d;
      div_q   <= div_d;
      sgn_q   <= sgn_d;
      ysgn_q  <= ysgn_d;
      dz_q    <= dz_d;
      c_q     <= c_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
      dzf_q   <= dzf_d;
      flags_q <= flags_d;
    end
  end

  assign bus.C        = c_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.div_zero = dzf_q;
`ifdef SEQ_ALU_FLAGS_EN
  assign bus.flags    = flags_q;
`else
  logic w_flags_unused;
  assign w_flags_unused = ^flags_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_seq_alu.sv
// +----------------------------------------------------------------------------+
// | tb_seq_alu : directed table-driven bench for seq_alu at WIDTH=32           |
// | Rev 1.0    : initial release                                               |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_seq_alu;
  localparam int WIDTH = 32;

  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_AND  = 5'b00101;
  localparam logic [4:0] OP_OR   = 5'b00110;
  localparam logic [4:0] OP_SHR  = 5'b00111;
  localparam logic [4:0] OP_SHRA = 5'b01000;
  localparam logic [4:0] OP_SHL  = 5'b01001;
  localparam logic [4:0] OP_ROR  = 5'b01010;
  localparam logic [4:0] OP_ROL  = 5'b01011;
  localparam logic [4:0] OP_MUL  = 5'b01111;
  localparam logic [4:0] OP_DIV  = 5'b10000;
  localparam logic [4:0] OP_NEG  = 5'b10001;
  localparam logic [4:0] OP_NOT  = 5'b10010;

  typedef struct {
    logic [4:0]  op;
    logic [31:0] y;
    logic [31:0] b;
    logic [63:0] c;
  } vec_t;

  logic clock;
  logic clear;
  int   errors;
  int   checks;

  seq_alu_if #(.WIDTH(WIDTH)) bus ();

  seq_alu #(.WIDTH(WIDTH)) dut (
    .clock (clock),
    .clear (clear),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%h expected 0x%h", name, act, exp);
    end
  endtask

  // Issues one mul/div at a negedge and returns the start-to-done latency in clocks
  task automatic run_multi(input logic [4:0] op, input logic [31:0] y, input logic [31:0] b,
                           input bit inject, output int lat, output int busy_bad);
    bus.start = 1'b1; bus.operation = op; bus.Y = y; bus.B = b;
    @(negedge clock);
    bus.start = 1'b0;
    lat = 0;
    busy_bad = 0;
    while (!bus.done && lat < 100) begin
      if (!bus.busy) busy_bad++;
      if (inject && lat == 10) begin
        bus.start = 1'b1; bus.operation = OP_ADD; bus.Y = 32'd100; bus.B = 32'd200;
      end
      if (inject && lat == 11) bus.start = 1'b0;
      @(negedge clock);
      lat++;
    end
  endtask

  task automatic multi_case(input string name, input logic [4:0] op, input logic [31:0] y,
                            input logic [31:0] b, input logic [63:0] exp_c, input logic exp_dz,
                            input bit inject);
    int lat, busy_bad;
    run_multi(op, y, b, inject, lat, busy_bad);
    check({name, "_latency"}, 64'(lat), 64'd33);
    check({name, "_busy_during"}, 64'(busy_bad), 64'd0);
    check({name, "_C"}, bus.C, exp_c);
    check({name, "_div_zero"}, 64'(bus.div_zero), 64'(exp_dz));
    check({name, "_busy_after"}, 64'(bus.busy), 64'd0);
    @(negedge clock);
    check({name, "_done_pulse"}, 64'(bus.done), 64'd0);
  endtask

  vec_t vecs[17];
  int   lat;
  int   busy_bad;
  int   late_done;

  initial begin
    errors = 0;
    checks = 0;
    vecs[0]  = '{OP_ADD,  32'd5,          32'd7,          64'h0000_0000_0000_000C};
    vecs[1]  = '{OP_ADD,  32'hFFFF_FFFF,  32'd1,          64'h0000_0000_0000_0000};
    vecs[2]  = '{OP_SUB,  32'd3,          32'd5,          64'h0000_0000_FFFF_FFFE};
    vecs[3]  = '{OP_AND,  32'hF0F0_F0F0,  32'hFF00_FF00,  64'h0000_0000_F000_F000};
    vecs[4]  = '{OP_OR,   32'h0000_0F00,  32'h0000_00F0,  64'h0000_0000_0000_0FF0};
    vecs[5]  = '{OP_SHR,  32'h8000_0000,  32'd4,          64'h0000_0000_0800_0000};
    vecs[6]  = '{OP_SHRA, 32'h8000_0000,  32'd4,          64'h0000_0000_F800_0000};
    vecs[7]  = '{OP_SHRA, 32'h7FFF_FFF0,  32'd4,          64'h0000_0000_07FF_FFFF};
    vecs[8]  = '{OP_SHL,  32'h0000_0001,  32'd31,         64'h0000_0000_8000_0000};
    vecs[9]  = '{OP_SHL,  32'h0000_0001,  32'd32,         64'h0000_0000_0000_0001};
    vecs[10] = '{OP_ROR,  32'h0000_0001,  32'd1,          64'h0000_0000_8000_0000};
    vecs[11] = '{OP_ROR,  32'h1234_5678,  32'd0,          64'h0000_0000_1234_5678};
    vecs[12] = '{OP_ROL,  32'h8000_0001,  32'd33,         64'h0000_0000_0000_0003};
    vecs[13] = '{OP_ROL,  32'h1234_5678,  32'd4,          64'h0000_0000_2345_6781};
    vecs[14] = '{OP_NEG,  32'd0,          32'd5,          64'h0000_0000_FFFF_FFFB};
    vecs[15] = '{OP_NOT,  32'd0,          32'h0000_FFFF,  64'h0000_0000_FFFF_0000};
    vecs[16] = '{5'b00000, 32'hDEAD_BEEF, 32'h1234_5678,  64'h0000_0000_0000_0000};

    clear = 1'b1;
    bus.start = 1'b0; bus.operation = '0; bus.Y = '0; bus.B = '0;
    repeat (2) @(negedge clock);
    check("reset_C", bus.C, 64'd0);
    check("reset_busy", 64'(bus.busy), 64'd0);
    check("reset_done", 64'(bus.done), 64'd0);
    check("reset_div_zero", 64'(bus.div_zero), 64'd0);
    clear = 1'b0;
    @(negedge clock);

    // Back-to-back single-cycle ops: one start per clock
    for (int i = 0; i < 17; i++) begin
      bus.start = 1'b1; bus.operation = vecs[i].op; bus.Y = vecs[i].y; bus.B = vecs[i].b;
      @(negedge clock);
      check($sformatf("vec%0d_C", i), bus.C, vecs[i].c);
      check($sformatf("vec%0d_done", i), 64'(bus.done), 64'd1);
      check($sformatf("vec%0d_busy", i), 64'(bus.busy), 64'd0);
    end
    bus.start = 1'b0;
    @(negedge clock);
    check("single_done_falls", 64'(bus.done), 64'd0);
    check("single_C_holds", bus.C, 64'd0);

    multi_case("mul_m3x7", OP_MUL, 32'hFFFF_FFFD, 32'd7, 64'hFFFF_FFFF_FFFF_FFEB, 1'b0, 1'b1);
    multi_case("mul_min_sq", OP_MUL, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000, 1'b0, 1'b0);
    multi_case("mul_m1_m1", OP_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'h0000_0000_0000_0001, 1'b0, 1'b0);
    multi_case("div_17_m5", OP_DIV, 32'd17, 32'hFFFF_FFFB, 64'h0000_0002_FFFF_FFFD, 1'b0, 1'b0);
    multi_case("div_m17_5", OP_DIV, 32'hFFFF_FFEF, 32'd5, 64'hFFFF_FFFE_FFFF_FFFD, 1'b0, 1'b0);
    multi_case("div_min_m1", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000, 1'b0, 1'b0);
    multi_case("div_by_zero", OP_DIV, 32'h0000_1234, 32'd0, 64'h0000_1234_FFFF_FFFF, 1'b1, 1'b0);

    // div_zero is sticky until the next accepted start
    check("dz_held", 64'(bus.div_zero), 64'd1);
    bus.start = 1'b1; bus.operation = OP_ADD; bus.Y = 32'd1; bus.B = 32'd2;
    @(negedge clock);
    bus.start = 1'b0;
    check("dz_cleared", 64'(bus.div_zero), 64'd0);
    check("dz_next_add_C", bus.C, 64'd3);

    // Abort a mul with clear at cycle 12
    bus.start = 1'b1; bus.operation = OP_MUL; bus.Y = 32'd9; bus.B = 32'd9;
    @(negedge clock);
    bus.start = 1'b0;
    repeat (12) @(negedge clock);
    check("abort_busy_before", 64'(bus.busy), 64'd1);
    clear = 1'b1;
    #1;
    check("abort_C", bus.C, 64'd0);
    check("abort_busy", 64'(bus.busy), 64'd0);
    check("abort_done", 64'(bus.done), 64'd0);
    @(negedge clock);
    clear = 1'b0;
    late_done = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clock);
      if (bus.done) late_done++;
    end
    check("abort_no_done", 64'(late_done), 64'd0);
    bus.start = 1'b1; bus.operation = OP_ADD; bus.Y = 32'd1; bus.B = 32'd1;
    @(negedge clock);
    bus.start = 1'b0;
    check("post_abort_add_C", bus.C, 64'd2);
    check("post_abort_add_done", 64'(bus.done), 64'd1);

    lat = 0;
    busy_bad = 0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
